// File: rtl/axis_video_sink.sv
// AXI4-Stream 8-bit video sink: checks SOF/EOL framing against the configured geometry,
// checksums and counts frames. Define AXIS_SINK_BACKPRESSURE_EN for LFSR-driven tready stalls.
module axis_video_sink #(
    parameter int FRAME_WIDTH        = 800,
    parameter int FRAME_HEIGHT       = 600,
    parameter int S_AXIS_TDATA_WIDTH = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            s_axis_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                            s_axis_tuser,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    input  logic                            enable,
    input  logic                            err_clear,
    output logic                            frame_done,
    output logic [31:0]                     frame_checksum,
    output logic [15:0]                     frame_count,
    output logic [3:0]                      err_flags
);

    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    logic [31:0]   sum_q, sum_d;
    logic [31:0]   csum_q, csum_d;
    logic [15:0]   count_q, count_d;
    logic [3:0]    err_q, err_d, err_set;
    logic          done_q, done_d;
    logic          tready_q, tready_d;
    logic          beat, pixel, start, line_end;
    logic          unused_tstrb;

    assign unused_tstrb = ^s_axis_tstrb;

`ifdef AXIS_SINK_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign tready_d = (state_d != IDLE) && lfsr_d[0];
`else
    assign tready_d = (state_d != IDLE);
`endif

    assign beat = s_axis_tvalid && tready_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        sum_d    = sum_q;
        csum_d   = csum_q;
        count_d  = count_q;
        done_d   = 1'b0;
        err_set  = '0;
        pixel    = 1'b0;
        start    = 1'b0;
        px       = x_q;
        py       = y_q;
        line_end = 1'b0;

        // Every accepted pixel is reduced to a position (px,py); a SOF beat always lands at (0,0).
        unique case (state_q)
            IDLE: if (enable) state_d = SYNC;
            SYNC: if (beat && s_axis_tuser) begin
                pixel = 1'b1;
                start = 1'b1;
            end
            ACTIVE: if (beat) begin
                if (s_axis_tuser) begin
                    pixel = 1'b1;
                    start = 1'b1;
                    if (x_q != '0 || y_q != '0) err_set[0] = 1'b1;
                end else if (x_q == '0 && y_q == '0) begin
                    err_set[3] = 1'b1;
                    state_d    = SYNC;
                end else begin
                    pixel = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            px = '0;
            py = '0;
        end

        if (pixel) begin
            state_d  = ACTIVE;
            sum_d    = start ? 32'(s_axis_tdata) : sum_q + 32'(s_axis_tdata);
            line_end = s_axis_tlast || (px == X_LAST);
            if (px == X_LAST && !s_axis_tlast) err_set[2] = 1'b1;
            if (px != X_LAST &&  s_axis_tlast) err_set[1] = 1'b1;
            if (line_end) begin
                x_d = '0;
                if (py == Y_LAST) begin
                    y_d     = '0;
                    done_d  = 1'b1;
                    csum_d  = sum_d;
                    count_d = count_q + 16'd1;
                    state_d = enable ? ACTIVE : IDLE;
                end else begin
                    y_d = py + 1'b1;
                end
            end else begin
                x_d = px + 1'b1;
                y_d = py;
            end
        end

        err_d = (err_clear ? 4'b0000 : err_q) | err_set;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            sum_q    <= '0;
            csum_q   <= '0;
            count_q  <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sum_q    <= sum_d;
            csum_q   <= csum_d;
            count_q  <= count_d;
            err_q    <= err_d;
            done_q   <= done_d;
            tready_q <= tready_d;
        end
    end

`ifdef AXIS_SINK_BACKPRESSURE_EN
    always_ff @(posedge aclk) begin
        if (areset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`endif

    assign s_axis_tready  = tready_q;
    assign frame_done     = done_q;
    assign frame_checksum = csum_q;
    assign frame_count    = count_q;
    assign err_flags      = err_q;

endmodule

// File: tb/tb_axis_video_sink.sv
// Directed self-checking bench for axis_video_sink with a 4x2 frame geometry.
module tb_axis_video_sink;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tdata;
    logic [0:0]  s_axis_tstrb;
    logic        s_axis_tuser;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        enable;
    logic        err_clear;
    logic        frame_done;
    logic [31:0] frame_checksum;
    logic [15:0] frame_count;
    logic [3:0]  err_flags;

    int tests = 0;
    int fails = 0;
    bit rand_gap = 1'b0;

    axis_video_sink #(
        .FRAME_WIDTH(4),
        .FRAME_HEIGHT(2),
        .S_AXIS_TDATA_WIDTH(8)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tstrb(s_axis_tstrb),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .enable(enable),
        .err_clear(err_clear),
        .frame_done(frame_done),
        .frame_checksum(frame_checksum),
        .frame_count(frame_count),
        .err_flags(err_flags)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send(input logic [7:0] d, input logic u, input logic l);
        int n = 0;
        if (rand_gap) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge aclk);
        end
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 200) check("tready_timeout", {31'b0, s_axis_tready}, 32'd1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] first, input logic [7:0] step);
        logic [7:0] d;
        for (int unsigned i = 0; i < 8; i++) begin
            d = first + 8'(i) * step;
            send(d, i == 0, i == 3 || i == 7);
            check("frame_done_clean", {31'b0, frame_done}, {31'b0, i == 7});
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"},   {31'b0, s_axis_tready}, 32'd0);
        check({tag, "_done"},     {31'b0, frame_done},    32'd0);
        check({tag, "_checksum"}, frame_checksum,         32'd0);
        check({tag, "_count"},    {16'b0, frame_count},   32'd0);
        check({tag, "_err"},      {28'b0, err_flags},     32'd0);
    endtask

    initial begin
        areset        = 1'b1;
        enable        = 1'b0;
        err_clear     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '1;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge aclk);
        check_all_zero("reset");
        areset = 1'b0;
        @(negedge aclk);
        check("idle_tready", {31'b0, s_axis_tready}, 32'd0);
        enable = 1'b1;
        @(negedge aclk);
`ifndef AXIS_SINK_BACKPRESSURE_EN
        check("sync_tready", {31'b0, s_axis_tready}, 32'd1);
`endif

        // Clean frame 1..8
        send_frame(8'd1, 8'd1);
        check("s1_checksum", frame_checksum, 32'd36);
        check("s1_count", {16'b0, frame_count}, 32'd1);
        check("s1_err", {28'b0, err_flags}, 32'd0);
        @(negedge aclk);
        check("s1_done_pulse", {31'b0, frame_done}, 32'd0);

        // Non-SOF beats discarded in SYNC, then all-0xFF frame
        do_reset();
        repeat (3) send(8'd5, 1'b0, 1'b0);
        send_frame(8'hFF, 8'd0);
        check("s2_checksum", frame_checksum, 32'd2040);
        check("s2_count", {16'b0, frame_count}, 32'd1);
        check("s2_err", {28'b0, err_flags}, 32'd0);

        // Early tlast on x=2: frame ends after 7 beats
        do_reset();
        for (int unsigned i = 0; i < 7; i++) begin
            send(8'(i + 1), i == 0, i == 2 || i == 6);
            check("s3_frame_done", {31'b0, frame_done}, {31'b0, i == 6});
        end
        check("s3_err", {28'b0, err_flags}, 32'd2);
        check("s3_checksum", frame_checksum, 32'd28);

        // SOF on 6th beat aborts; the restarted frame completes
        do_reset();
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        send(8'd4, 1'b0, 1'b1);
        send(8'd5, 1'b0, 1'b0);
        send(8'd10, 1'b1, 1'b0);
        check("s4_sof_early", {28'b0, err_flags}, 32'd1);
        for (int unsigned i = 1; i < 8; i++) begin
            send(8'(10 + i), 1'b0, i == 3 || i == 7);
            check("s4_frame_done", {31'b0, frame_done}, {31'b0, i == 7});
        end
        check("s4_count", {16'b0, frame_count}, 32'd1);
        check("s4_checksum", frame_checksum, 32'd108);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        check("s4_err_clear", {28'b0, err_flags}, 32'd0);
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b1, 1'b0);
        check("s4_sof_early2", {28'b0, err_flags}, 32'd1);
        err_clear = 1'b1;
        send(8'd3, 1'b0, 1'b1);
        err_clear = 1'b0;
        check("s4_clear_vs_set", {28'b0, err_flags}, 32'd2);

        // Back-to-back frames, enable ignored mid-frame, then reset mid-frame
        do_reset();
        send_frame(8'd1, 8'd1);
        send_frame(8'd1, 8'd1);
        check("s5_count", {16'b0, frame_count}, 32'd2);
        check("s5_checksum", frame_checksum, 32'd36);
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        enable = 1'b0;
        send(8'd3, 1'b1, 1'b0);
        check("s5_sof_early", {28'b0, err_flags}, 32'd1);
        check("s5_no_done", {31'b0, frame_done}, 32'd0);
        areset = 1'b1;
        @(negedge aclk);
        check_all_zero("s5_areset");
        areset = 1'b0;
        enable = 1'b1;

        // Missing tlast at x=3; enable dropped mid-frame takes effect at frame end
        do_reset();
        for (int unsigned i = 0; i < 8; i++) begin
            send(8'(i + 1), i == 0, i == 7);
            check("s6_frame_done", {31'b0, frame_done}, {31'b0, i == 7});
            if (i == 4) enable = 1'b0;
        end
        check("s6_err", {28'b0, err_flags}, 32'd4);
        check("s6_checksum", frame_checksum, 32'd36);
        check("s6_idle_tready", {31'b0, s_axis_tready}, 32'd0);
        enable = 1'b1;

        // 100 frames of value 1 with random tvalid gaps
        do_reset();
        rand_gap = 1'b1;
        for (int unsigned f = 0; f < 100; f++) begin
            send_frame(8'd1, 8'd0);
            check("s7_checksum", frame_checksum, 32'd8);
        end
        rand_gap = 1'b0;
        check("s7_count", {16'b0, frame_count}, 32'd100);
        check("s7_err", {28'b0, err_flags}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
